// File: rtl/switch_debounce_capture_pkg.sv
// Shared defaults and helpers for the switch conditioning block.
// Imported by the interface, the per-bit debouncer and the top.
package sw_cond_pkg;

    localparam int SW_WIDTH           = 8;
    localparam int SW_DEBOUNCE_CYCLES = 16;

    // Counter only has to reach DEBOUNCE_CYCLES-1, so log2 of the cycle count is enough.
    function automatic int cntWidth(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    function automatic logic isOneHot(input logic [31:0] vec);
        return ($countones(vec) == 1);
    endfunction

endpackage

// File: rtl/switch_debounce_capture_if.sv
// Valid/ready request channel from the switch conditioner to the priority decoder.
// The master (switch_debounce_capture) drives valid/data; the slave returns ready.
interface switch_debounce_capture_if
    import sw_cond_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH
);

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);

endinterface

// File: rtl/switch_debounce_capture_debounce_bit.sv
// One switch bit: two-flop synchroniser, then a run-length debounce counter
// that only accepts a new level after DEBOUNCE_CYCLES consecutive enabled mismatches.
module debounce_bit
    import sw_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cntWidth(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic sw_i,
    output logic stable_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The synchroniser keeps running while disabled so the level is fresh on re-enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (ena) begin
            if (sync2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/switch_debounce_capture.sv
// Switch input conditioner: per-bit debounce, then publish each new non-zero stable vector
// on a valid/ready channel with sticky overrun. Optional macro ONEHOT_FILTER_EN rejects multi-bit vectors.
module switch_debounce_capture
    import sw_cond_pkg::*;
#(
    parameter int   WIDTH           = SW_WIDTH,
    parameter int   DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    localparam int  CNT_W           = cntWidth(DEBOUNCE_CYCLES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [WIDTH-1:0]          sw_in,
    switch_debounce_capture_if.master req,
    input  logic                      ovr_clr,
    output logic [WIDTH-1:0]          sw_stable,
    output logic                      overrun,
    output logic                      err_multi
);

    logic [1:0]       rstSync_q;
    logic             rstInt;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] dPrev_q;
    logic [WIDTH-1:0] dPrev_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             change;
    logic             nonZero;
    logic             accept;
    logic             publish;

    // Reset asserts immediately but is released two clock edges later, cleanly aligned to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstSync_q <= 2'b11;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b0};
        end
    end

    assign rstInt = rstSync_q[1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk      (clk),
            .rst      (rstInt),
            .ena      (ena),
            .sw_i     (sw_in[i]),
            .stable_o (stable[i])
        );
    end

    assign change  = ena && (stable != dPrev_q);
    assign nonZero = |stable;

`ifdef ONEHOT_FILTER_EN
    logic errMulti_q;
    logic errMulti_d;

    assign accept     = isOneHot(32'(stable));
    assign errMulti_d = change && nonZero && !accept;

    always_ff @(posedge clk or posedge rstInt) begin
        if (rstInt) begin
            errMulti_q <= 1'b0;
        end else begin
            errMulti_q <= errMulti_d;
        end
    end

    assign err_multi = errMulti_q;
`else
    assign accept    = 1'b1;
    assign err_multi = 1'b0;
`endif

    assign publish = change && nonZero && accept;

    // A new publish always wins over the transfer; overrun only if the old vector was not taken.
    always_comb begin
        dPrev_d   = ena ? stable : dPrev_q;
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (publish) begin
            valid_d = 1'b1;
            data_d  = stable;
        end else if (valid_q && req.req_ready) begin
            valid_d = 1'b0;
        end
        if (publish && valid_q && !req.req_ready) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rstInt) begin
        if (rstInt) begin
            dPrev_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            dPrev_q   <= dPrev_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign req.req_valid = valid_q;
    assign req.req_data  = data_q;
    assign sw_stable     = stable;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_switch_debounce_capture.sv
// Self-checking bench for switch_debounce_capture: directed scenarios with fixed expectations,
// then a randomized run compared cycle by cycle against a behavioural model of the block.
module tb_switch_debounce_capture;

    localparam int WIDTH = 8;
    localparam int DC    = 16;

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic             ena     = 1'b0;
    logic             ovr_clr = 1'b0;
    logic [WIDTH-1:0] sw_in   = '0;
    logic [WIDTH-1:0] sw_stable;
    logic             overrun;
    logic             err_multi;

    int checks = 0;
    int errors = 0;

    switch_debounce_capture_if #(.WIDTH(WIDTH)) reqIf ();

    switch_debounce_capture #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .sw_in     (sw_in),
        .req       (reqIf),
        .ovr_clr   (ovr_clr),
        .sw_stable (sw_stable),
        .overrun   (overrun),
        .err_multi (err_multi)
    );

    always #5 clk = ~clk;

    // Reference model: sampled switch history, per-bit disagreement run lengths, output queue slot.
    logic [WIDTH-1:0] mP1 = '0, mS = '0, mD = '0, mPrev = '0, mData = '0;
    logic             mValid = 1'b0, mOvr = 1'b0, mErr = 1'b0;
    int               mRun [WIDTH];
    int               mHold = 0;
    logic [WIDTH-1:0] dOld;
    logic             pub, ovrSet;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mP1 = '0; mS = '0; mD = '0; mPrev = '0; mData = '0;
            mValid = 1'b0; mOvr = 1'b0; mErr = 1'b0; mHold = 2;
            for (int i = 0; i < WIDTH; i++) mRun[i] = 0;
        end else if (mHold > 0) begin
            mHold = mHold - 1;
        end else begin
            dOld = mD;
            pub  = 1'b0;
            mErr = 1'b0;
            if (ena && dOld != mPrev && dOld != '0) begin
`ifdef ONEHOT_FILTER_EN
                if ($countones(dOld) == 1) pub = 1'b1;
                else mErr = 1'b1;
`else
                pub = 1'b1;
`endif
            end
            if (ena) mPrev = dOld;
            ovrSet = pub && mValid && !reqIf.req_ready;
            if (ovrSet) mOvr = 1'b1;
            else if (ovr_clr) mOvr = 1'b0;
            if (pub) begin
                mValid = 1'b1;
                mData  = dOld;
            end else if (mValid && reqIf.req_ready) begin
                mValid = 1'b0;
            end
            if (ena) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (mS[i] == mD[i]) mRun[i] = 0;
                    else if (mRun[i] == DC - 1) begin
                        mD[i]   = mS[i];
                        mRun[i] = 0;
                    end else mRun[i] = mRun[i] + 1;
                end
            end
            mS  = mP1;
            mP1 = sw_in;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic goIdle();
        sw_in = '0; ena = 1'b1; ovr_clr = 1'b0;
        reqIf.req_ready = 1'b1;
        tick(25);
        reqIf.req_ready = 1'b0;
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        reqIf.req_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (reqIf.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL por_valid got %b exp 0", reqIf.req_valid); end
        checks++; if (reqIf.req_data !== 8'h00) begin errors++; $display("[TB] FAIL por_data got %h exp 00", reqIf.req_data); end
        checks++; if (sw_stable !== 8'h00) begin errors++; $display("[TB] FAIL por_stable got %h exp 00", sw_stable); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL por_overrun got %b exp 0", overrun); end
        checks++; if (err_multi !== 1'b0) begin errors++; $display("[TB] FAIL por_err got %b exp 0", err_multi); end
        tick(3);
        sw_in = 8'hFF; ena = 1'b1;
        rst = 1'b0;
        tick(40);
`ifdef ONEHOT_FILTER_EN
        checks++; if (reqIf.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rel_valid got %b exp 0", reqIf.req_valid); end
`else
        checks++; if (reqIf.req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rel_valid got %b exp 1", reqIf.req_valid); end
        checks++; if (reqIf.req_data !== 8'hFF) begin errors++; $display("[TB] FAIL rel_data got %h exp FF", reqIf.req_data); end
`endif
        checks++; if (sw_stable !== 8'hFF) begin errors++; $display("[TB] FAIL rel_stable got %h exp FF", sw_stable); end
        rst = 1'b1;
        #1;
        checks++; if (reqIf.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got %b exp 0", reqIf.req_valid); end
        checks++; if (reqIf.req_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_data got %h exp 00", reqIf.req_data); end
        checks++; if (sw_stable !== 8'h00) begin errors++; $display("[TB] FAIL mid_stable got %h exp 00", sw_stable); end
        sw_in = 8'h00;
        tick(3);
        rst = 1'b0;
        tick(30);
        checks++; if (reqIf.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_valid got %b exp 0", reqIf.req_valid); end
        checks++; if (reqIf.req_data !== 8'h00) begin errors++; $display("[TB] FAIL post_data got %h exp 00", reqIf.req_data); end
    endtask

    task automatic test_clean_press();
        goIdle();
        sw_in = 8'h04;
        tick(18);
        checks++; if (reqIf.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL press_early_valid got %b exp 0", reqIf.req_valid); end
        checks++; if (sw_stable !== 8'h04) begin errors++; $display("[TB] FAIL press_stable got %h exp 04", sw_stable); end
        tick(1);
        checks++; if (reqIf.req_valid !== 1'b1) begin errors++; $display("[TB] FAIL press_valid got %b exp 1", reqIf.req_valid); end
        checks++; if (reqIf.req_data !== 8'h04) begin errors++; $display("[TB] FAIL press_data got %h exp 04", reqIf.req_data); end
        tick(3);
        checks++; if (reqIf.req_valid !== 1'b1 || reqIf.req_data !== 8'h04) begin errors++; $display("[TB] FAIL press_hold got %b/%h exp 1/04", reqIf.req_valid, reqIf.req_data); end
        reqIf.req_ready = 1'b1;
        tick(1);
        reqIf.req_ready = 1'b0;
        checks++; if (reqIf.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL press_xfer got %b exp 0", reqIf.req_valid); end
        sw_in = 8'h00;
        tick(20);
        checks++; if (sw_stable !== 8'h00) begin errors++; $display("[TB] FAIL release_stable got %h exp 00", sw_stable); end
        checks++; if (reqIf.req_valid !== 1'b0 || reqIf.req_data !== 8'h04) begin errors++; $display("[TB] FAIL release_nopub got %b/%h exp 0/04", reqIf.req_valid, reqIf.req_data); end
    endtask

    task automatic test_bounce();
        int rises = 0;
        goIdle();
        for (int k = 0; k < 12; k++) begin
            sw_in = (k % 2 == 0) ? 8'h08 : 8'h00;
            for (int c = 0; c < 5; c++) begin
                tick(1);
                if (reqIf.req_valid === 1'b1) rises++;
            end
        end
        checks++; if (rises !== 0) begin errors++; $display("[TB] FAIL bounce_nopub got %0d exp 0", rises); end
        sw_in = 8'h08;
        tick(18);
        checks++; if (reqIf.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL bounce_early got %b exp 0", reqIf.req_valid); end
        tick(1);
        checks++; if (reqIf.req_valid !== 1'b1 || reqIf.req_data !== 8'h08) begin errors++; $display("[TB] FAIL bounce_pub got %b/%h exp 1/08", reqIf.req_valid, reqIf.req_data); end
    endtask

    task automatic test_overrun();
        goIdle();
        sw_in = 8'h01;
        tick(19);
        checks++; if (reqIf.req_valid !== 1'b1 || reqIf.req_data !== 8'h01) begin errors++; $display("[TB] FAIL ovr_first got %b/%h exp 1/01", reqIf.req_valid, reqIf.req_data); end
        sw_in = 8'h02;
        tick(18);
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_early got %b exp 0", overrun); end
        tick(1);
        checks++; if (reqIf.req_data !== 8'h02) begin errors++; $display("[TB] FAIL ovr_data got %h exp 02", reqIf.req_data); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag got %b exp 1", overrun); end
        tick(2);
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky got %b exp 1", overrun); end
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clr got %b exp 0", overrun); end
        checks++; if (reqIf.req_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_valid got %b exp 1", reqIf.req_valid); end
    endtask

    task automatic test_back_to_back();
        goIdle();
        sw_in = 8'h01;
        tick(19);
        sw_in = 8'h02;
        tick(18);
        reqIf.req_ready = 1'b1;
        tick(1);
        reqIf.req_ready = 1'b0;
        checks++; if (reqIf.req_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid got %b exp 1", reqIf.req_valid); end
        checks++; if (reqIf.req_data !== 8'h02) begin errors++; $display("[TB] FAIL b2b_data got %h exp 02", reqIf.req_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun got %b exp 0", overrun); end
    endtask

    task automatic test_enable();
        goIdle();
        sw_in = 8'h10;
        tick(8);
        ena = 1'b0;
        tick(30);
        checks++; if (sw_stable !== 8'h00 || reqIf.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL ena_frozen got %h/%b exp 00/0", sw_stable, reqIf.req_valid); end
        ena = 1'b1;
        tick(9);
        checks++; if (sw_stable !== 8'h00) begin errors++; $display("[TB] FAIL ena_remaining got %h exp 00", sw_stable); end
        tick(1);
        checks++; if (sw_stable !== 8'h10 || reqIf.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL ena_stable got %h/%b exp 10/0", sw_stable, reqIf.req_valid); end
        tick(1);
        checks++; if (reqIf.req_valid !== 1'b1 || reqIf.req_data !== 8'h10) begin errors++; $display("[TB] FAIL ena_pub got %b/%h exp 1/10", reqIf.req_valid, reqIf.req_data); end
        ena = 1'b0;
        reqIf.req_ready = 1'b1;
        tick(1);
        reqIf.req_ready = 1'b0;
        ena = 1'b1;
        checks++; if (reqIf.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL ena_xfer got %b exp 0", reqIf.req_valid); end
    endtask

    task automatic test_onehot_filter();
        int errCount = 0;
        goIdle();
        sw_in = 8'h0C;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            if (err_multi === 1'b1) errCount++;
        end
`ifdef ONEHOT_FILTER_EN
        checks++; if (errCount !== 1) begin errors++; $display("[TB] FAIL multi_err_pulses got %0d exp 1", errCount); end
        checks++; if (reqIf.req_valid !== 1'b0) begin errors++; $display("[TB] FAIL multi_nopub got %b exp 0", reqIf.req_valid); end
`else
        checks++; if (errCount !== 0) begin errors++; $display("[TB] FAIL multi_err_pulses got %0d exp 0", errCount); end
        checks++; if (reqIf.req_valid !== 1'b1 || reqIf.req_data !== 8'h0C) begin errors++; $display("[TB] FAIL multi_pub got %b/%h exp 1/0C", reqIf.req_valid, reqIf.req_data); end
`endif
    endtask

    task automatic test_random();
        int holdLeft = 0;
        int r;
        goIdle();
        for (int cyc = 0; cyc < 2500; cyc++) begin
            tick(1);
            checks++; if (reqIf.req_valid !== mValid) begin errors++; $display("[TB] FAIL rand_valid cyc %0d got %b exp %b", cyc, reqIf.req_valid, mValid); end
            checks++; if (reqIf.req_data !== mData) begin errors++; $display("[TB] FAIL rand_data cyc %0d got %h exp %h", cyc, reqIf.req_data, mData); end
            checks++; if (sw_stable !== mD) begin errors++; $display("[TB] FAIL rand_stable cyc %0d got %h exp %h", cyc, sw_stable, mD); end
            checks++; if (overrun !== mOvr) begin errors++; $display("[TB] FAIL rand_overrun cyc %0d got %b exp %b", cyc, overrun, mOvr); end
            checks++; if (err_multi !== mErr) begin errors++; $display("[TB] FAIL rand_err cyc %0d got %b exp %b", cyc, err_multi, mErr); end
            if (holdLeft == 0) begin
                r = $urandom_range(0, 9);
                if (r < 3) sw_in = 8'h00;
                else if (r < 7) sw_in = 8'(32'd1 << $urandom_range(0, 7));
                else sw_in = 8'($urandom);
                holdLeft = $urandom_range(1, 45);
            end else begin
                holdLeft--;
            end
            reqIf.req_ready = ($urandom_range(0, 3) == 0);
            ovr_clr         = ($urandom_range(0, 15) == 0);
            ena             = ($urandom_range(0, 15) != 0);
            rst             = ($urandom_range(0, 599) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        reqIf.req_ready = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_overrun();
        test_back_to_back();
        test_enable();
        test_onehot_filter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
